// File: rtl/usbfifo_tx.sv
// Transmit engine for the FT2232H async 245 FIFO: buffers bytes from a valid/ready
// source and replays them as timed WR# strobes gated by the synchronised TXE# flag.
module usbfifo_tx #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned AW          = 4,
    parameter int unsigned SETUP_CYC   = 1,
    parameter int unsigned PULSE_CYC   = 2,
    parameter int unsigned HOLD_CYC    = 1,
    parameter int unsigned RECOVER_CYC = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          txe,
    output logic          wr,
    output logic [7:0]    data_out,
    output logic          data_oe,
    output logic [AW:0]   fifo_count,
    output logic          busy
);

    localparam int unsigned MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int unsigned MAX_HR  = (HOLD_CYC > RECOVER_CYC) ? HOLD_CYC : RECOVER_CYC;
    localparam int unsigned MAX_CYC = (MAX_SP > MAX_HR) ? MAX_SP : MAX_HR;
    localparam int unsigned CW      = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOVER} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            txe_m, txe_s;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            push, pop;
    logic            wr_d, oe_d, busy_d;

    assign in_ready = !reset && (fifo_count != (AW+1)'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (state == IDLE) && !txe_s && (fifo_count != '0);

    // State, phase counter and registered pin controls
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            wr      <= 1'b1;
            data_oe <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            wr      <= wr_d;
            data_oe <= oe_d;
            busy    <= busy_d;
        end
    end

    // Next state: each timed phase reloads the shared down-counter on entry
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (pop) begin
                    state_nxt = SETUP;
                    cnt_nxt   = CW'(SETUP_CYC - 1);
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_nxt = STROBE;
                    cnt_nxt   = CW'(PULSE_CYC - 1);
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            STROBE: begin
                if (cnt == '0) begin
                    state_nxt = HOLD;
                    cnt_nxt   = CW'(HOLD_CYC - 1);
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_nxt = RECOVER;
                    cnt_nxt   = CW'(RECOVER_CYC - 1);
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            RECOVER: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Pin controls decoded from the next state so the registers change with it
    always_comb begin
        wr_d   = 1'b1;
        oe_d   = 1'b0;
        busy_d = (state_nxt != IDLE);
        case (state_nxt)
            SETUP:   oe_d = 1'b1;
            STROBE: begin
                wr_d = 1'b0;
                oe_d = 1'b1;
            end
            HOLD:    oe_d = 1'b1;
            default: oe_d = 1'b0;
        endcase
    end

    // Buffer pointers, occupancy, output byte and TXE# synchroniser
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            data_out   <= '0;
            txe_m      <= 1'b1;
            txe_s      <= 1'b1;
        end else begin
            txe_m <= txe;
            txe_s <= txe_m;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_usbfifo_tx.sv
// Scoreboard bench for usbfifo_tx: accepted bytes are queued and checked against
// each WR# strobe, alongside strobe timing, phase ordering and reset behaviour.
module tb_usbfifo_tx;

    localparam int unsigned PULSE  = 2;
    localparam int unsigned PERIOD = 7;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        txe;
    logic        wr;
    logic [7:0]  data_out;
    logic        data_oe;
    logic [4:0]  fifo_count;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          pulses = 0;
    int          low_cnt = 0;
    int          last_fall = 0;
    bit          last_valid = 1'b0;
    bit          chk_gap = 1'b0;
    logic        rst_q = 1'b1;
    logic        prev_wr, prev_oe;
    logic [7:0]  prev_data;
    logic [7:0]  sb [$];

    usbfifo_tx dut (
        .clock      (clock),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .txe        (txe),
        .wr         (wr),
        .data_out   (data_out),
        .data_oe    (data_oe),
        .fifo_count (fifo_count),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc++;
        rst_q = reset;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d);
        in_data  = d;
        in_valid = 1'b1;
        if (in_ready === 1'b1) sb.push_back(d);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_wr_low(input int max);
        int n = 0;
        while (wr !== 1'b0 && n < max) begin
            tick();
            n++;
        end
        check("wr_low_seen", 32'(wr), 32'd0);
    endtask

    task automatic drain(input int max);
        int n = 0;
        while ((sb.size() != 0 || busy !== 1'b0) && n < max) begin
            tick();
            n++;
        end
        check("drain_sb", 32'(sb.size()), 32'd0);
        check("drain_busy", 32'(busy), 32'd0);
    endtask

    // Strobe monitor: data, setup/hold enables, pulse width, spacing, data stability
    always @(negedge clock) begin
        if (wr === 1'b0) begin
            if (prev_wr === 1'b1) begin
                pulses++;
                low_cnt = 1;
                check("setup_oe", 32'(prev_oe), 32'd1);
                check("wr_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) check("wr_data", 32'(data_out), 32'(sb.pop_front()));
                if (chk_gap && last_valid) check("wr_gap", 32'(cyc - last_fall), 32'(PERIOD));
                last_fall  = cyc;
                last_valid = chk_gap;
            end else begin
                low_cnt++;
            end
            check("strobe_oe", 32'(data_oe), 32'd1);
        end else if (prev_wr === 1'b0 && wr === 1'b1 && rst_q === 1'b0) begin
            check("wr_width", 32'(low_cnt), 32'(PULSE));
            check("hold_oe", 32'(data_oe), 32'd1);
        end
        if (data_oe === 1'b1 && prev_oe === 1'b1) check("data_stable", 32'(data_out), 32'(prev_data));
        prev_wr   = wr;
        prev_oe   = data_oe;
        prev_data = data_out;
    end

    initial begin
        int p0;
        int n;
        int i;
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h77;
        txe      = 1'b0;

        // Reset held with a valid byte offered
        repeat (3) begin
            tick();
            check("rst_wr", 32'(wr), 32'd1);
            check("rst_oe", 32'(data_oe), 32'd0);
            check("rst_ready", 32'(in_ready), 32'd0);
            check("rst_count", 32'(fifo_count), 32'd0);
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("ready_after_rst", 32'(in_ready), 32'd1);
        repeat (4) tick();
        check("no_byte_after_rst", 32'(pulses), 32'd0);

        // Single byte latency and phase timing
        push_byte(8'h5A);
        check("n0_count", 32'(fifo_count), 32'd1);
        check("n0_oe", 32'(data_oe), 32'd0);
        tick();
        check("n1_oe", 32'(data_oe), 32'd1);
        check("n1_wr", 32'(wr), 32'd1);
        check("n1_data", 32'(data_out), 32'h5A);
        check("n1_busy", 32'(busy), 32'd1);
        check("n1_count", 32'(fifo_count), 32'd0);
        tick();
        check("n2_wr", 32'(wr), 32'd0);
        tick();
        check("n3_wr", 32'(wr), 32'd0);
        tick();
        check("n4_wr", 32'(wr), 32'd1);
        check("n4_oe", 32'(data_oe), 32'd1);
        tick();
        check("n5_oe", 32'(data_oe), 32'd0);
        check("n5_busy", 32'(busy), 32'd1);
        tick();
        check("n6_busy", 32'(busy), 32'd1);
        tick();
        check("n7_busy", 32'(busy), 32'd0);

        // Fill to full with TXE# high, then drain at the nominal rate
        txe = 1'b1;
        repeat (3) tick();
        for (int k = 0; k < 17; k++) begin
            in_data  = 8'(k);
            in_valid = 1'b1;
            check("fill_ready", 32'(in_ready), 32'(k < 16));
            if (in_ready === 1'b1) sb.push_back(8'(k));
            tick();
        end
        in_valid = 1'b0;
        check("full_count", 32'(fifo_count), 32'd16);
        check("full_ready", 32'(in_ready), 32'd0);
        chk_gap = 1'b1;
        p0  = pulses;
        txe = 1'b0;
        drain(300);
        check("full_pulses", 32'(pulses - p0), 32'd16);
        chk_gap = 1'b0;

        // TXE# raised mid-strobe: pulse completes, next byte waits for sync
        push_byte(8'hA1);
        push_byte(8'hA2);
        wait_wr_low(20);
        txe = 1'b1;
        n = 0;
        while (busy !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        check("txe_hi_idle", 32'(busy), 32'd0);
        repeat (5) begin
            tick();
            check("txe_hi_oe", 32'(data_oe), 32'd0);
            check("txe_hi_count", 32'(fifo_count), 32'd1);
        end
        txe = 1'b0;
        tick();
        check("txe_sync1_oe", 32'(data_oe), 32'd0);
        tick();
        check("txe_sync2_oe", 32'(data_oe), 32'd0);
        tick();
        check("txe_sync3_oe", 32'(data_oe), 32'd1);
        drain(40);

        // Push and pop on the same edge at count 15, then stream across the wrap
        txe = 1'b1;
        repeat (3) tick();
        for (int k = 0; k < 15; k++) push_byte(8'(8'h80 + k));
        check("c15_count", 32'(fifo_count), 32'd15);
        chk_gap = 1'b1;
        txe = 1'b0;
        tick();
        tick();
        in_data  = 8'hC0;
        in_valid = 1'b1;
        if (in_ready === 1'b1) sb.push_back(8'hC0);
        tick();
        in_valid = 1'b0;
        check("c15_same_edge", 32'(fifo_count), 32'd15);
        check("c15_pop_oe", 32'(data_oe), 32'd1);
        check("c15_pop_data", 32'(data_out), 32'h80);
        i = 0;
        n = 0;
        while (i < 40 && n < 2000) begin
            in_data  = 8'($urandom_range(0, 255));
            in_valid = 1'b1;
            if (in_ready === 1'b1) begin
                sb.push_back(in_data);
                i++;
            end
            tick();
            n++;
        end
        in_valid = 1'b0;
        check("stream_accepted", 32'(i), 32'd40);
        drain(800);
        chk_gap = 1'b0;

        // Reset during a strobe discards the byte in flight and the buffer
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        wait_wr_low(20);
        reset = 1'b1;
        tick();
        check("mid_rst_wr", 32'(wr), 32'd1);
        check("mid_rst_oe", 32'(data_oe), 32'd0);
        check("mid_rst_count", 32'(fifo_count), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd0);
        sb.delete();
        reset = 1'b0;
        p0 = pulses;
        repeat (20) tick();
        check("post_rst_pulses", 32'(pulses - p0), 32'd0);
        check("post_rst_ready", 32'(in_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
